// File: rtl/io_bus_master.sv
// Bus initiator for the 8-bit peripheral bus: runs single read/write commands and
// self-serviced interrupt-status reads, each completing on an acknowledge or a timeout.
module io_bus_master #(
    parameter int unsigned              address_width    = 16,
    parameter int unsigned              data_width       = 8,
    parameter int unsigned              TimeoutCycles    = 8,
    parameter logic [address_width-1:0] IdleAddress      = '1,
    parameter logic [address_width-1:0] IrqStatusAddress = address_width'(3)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [address_width-1:0] cmd_address_i,
    input  logic [data_width-1:0]    cmd_data_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [data_width-1:0]    rsp_data_o,
    output logic                     rsp_error_o,
    output logic                     irq_status_valid_o,
    output logic [data_width-1:0]    irq_status_o,
    output logic                     irq_error_o,
    output logic [address_width-1:0] address_o,
    output logic [data_width-1:0]    data_o,
    output logic                     rd_wr_o,
    input  logic [data_width-1:0]    data_i,
    input  logic                     take_controlr_i,
    input  logic                     take_controlw_i,
    input  logic                     irq_i
);

    localparam int unsigned           CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0]   CntMax   = CntWidth'(TimeoutCycles);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP,
        ST_IRQDONE
    } state_t;

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q;
    logic                  last_irq_q;
    logic                  is_irq_q;

    logic                  arb_irq;
    logic                  start_irq;
    logic                  accept;
    logic                  ack;
    logic                  ack_ok;
    logic                  timed_out;
    logic                  bus_done;
    logic [data_width-1:0] rd_result;

    always_comb begin
        // A command left waiting by the previous IRQ service beats a still-high irq_i
        arb_irq     = irq_i && !(last_irq_q && cmd_valid_i);
        start_irq   = (state_q == ST_IDLE) && arb_irq;
        cmd_ready_o = reset_i && (state_q == ST_IDLE) && !arb_irq;
        accept      = cmd_valid_i && cmd_ready_o;
        ack         = rd_wr_o ? take_controlw_i : take_controlr_i;
        ack_ok      = (state_q == ST_BUS) && ack && (cnt_q != '0);
        timed_out   = (state_q == ST_BUS) && !ack_ok && (cnt_q == CntMax);
        bus_done    = ack_ok || timed_out;
        rd_result   = (ack_ok && !rd_wr_o) ? data_i : '0;

        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_irq || accept) state_d = ST_BUS;
            ST_BUS:     if (bus_done) state_d = is_irq_q ? ST_IRQDONE : ST_RESP;
            ST_RESP:    if (rsp_ready_i) state_d = ST_IDLE;
            ST_IRQDONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q              <= '0;
            last_irq_q         <= 1'b0;
            is_irq_q           <= 1'b0;
            address_o          <= IdleAddress;
            data_o             <= '0;
            rd_wr_o            <= 1'b0;
            rsp_valid_o        <= 1'b0;
            rsp_data_o         <= '0;
            rsp_error_o        <= 1'b0;
            irq_status_valid_o <= 1'b0;
            irq_status_o       <= '0;
            irq_error_o        <= 1'b0;
        end else begin
            irq_status_valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_irq) begin
                        address_o <= IrqStatusAddress;
                        rd_wr_o   <= 1'b0;
                        data_o    <= '0;
                        is_irq_q  <= 1'b1;
                    end else if (accept) begin
                        address_o  <= cmd_address_i;
                        rd_wr_o    <= cmd_write_i;
                        data_o     <= cmd_write_i ? cmd_data_i : '0;
                        is_irq_q   <= 1'b0;
                        last_irq_q <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        address_o <= IdleAddress;
                        rd_wr_o   <= 1'b0;
                        data_o    <= '0;
                        cnt_q     <= '0;
                        if (is_irq_q) begin
                            irq_status_valid_o <= 1'b1;
                            irq_status_o       <= rd_result;
                            irq_error_o        <= timed_out;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= rd_result;
                            rsp_error_o <= timed_out;
                        end
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) rsp_valid_o <= 1'b0;
                end
                ST_IRQDONE: begin
                    last_irq_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: transaction-level expected-output model plus a
// peripheral responder, directed scenarios, then a randomized phase.
module tb_io_bus_master;

    localparam int unsigned T         = 8;
    localparam logic [15:0] IDLE_ADDR = 16'hFFFF;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [15:0] cmd_address_i = '0;
    logic [7:0]  cmd_data_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [7:0]  rsp_data_o;
    logic        rsp_error_o;
    logic        irq_status_valid_o;
    logic [7:0]  irq_status_o;
    logic        irq_error_o;
    logic [15:0] address_o;
    logic [7:0]  data_o;
    logic        rd_wr_o;
    logic [7:0]  data_i = '0;
    logic        take_controlr_i = 1'b0;
    logic        take_controlw_i = 1'b0;
    logic        irq_i = 1'b0;

    io_bus_master #(
        .address_width(16),
        .data_width(8),
        .TimeoutCycles(T),
        .IdleAddress(16'hFFFF),
        .IrqStatusAddress(16'h0003)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_address_i(cmd_address_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_error_o(rsp_error_o), .irq_status_valid_o(irq_status_valid_o),
        .irq_status_o(irq_status_o), .irq_error_o(irq_error_o),
        .address_o(address_o), .data_o(data_o), .rd_wr_o(rd_wr_o), .data_i(data_i),
        .take_controlr_i(take_controlr_i), .take_controlw_i(take_controlw_i), .irq_i(irq_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Peripheral plan for the current transaction, chosen when it is issued
    int         p_ack_at = 1000;
    bit         p_stale = 0;
    bit         p_wr = 0;
    logic [7:0] p_rdval = '0;
    int         p_idx = -1;
    bit         dir_plan = 1;
    bit         noise_on = 0;
    int         next_ack_at = 1;
    logic [7:0] next_rdval = '0;

    // Expected-behaviour model: a bus window of known length, then one result
    int          m_bus_left = 0;
    logic [15:0] m_addr = '0;
    bit          m_wr = 0;
    logic [7:0]  m_wdata = '0;
    bit          m_irq = 0;
    bit          m_last_irq = 0;
    bit          m_rsp = 0;
    bit          m_pulse = 0;
    logic [7:0]  m_res_data = '0;
    bit          m_res_err = 0;
    bit          exp_idle, exp_ready, ok, take_irq;

    // Observations used by the literal checks
    int          cyc = 0;
    bit          acc_evt = 0;
    int          acc_cyc = 0;
    int          run_len = 0;
    int          last_len = 0;
    bit          prev_rsp = 0;
    int          rsp_rise_cyc = 0;
    logic [7:0]  last_rsp_data = '0;
    bit          last_rsp_err = 0;
    int          pulse_count = 0;
    int          pulse_cyc = 0;
    logic [7:0]  last_status = '0;

    always @(negedge clk_i) begin
        cyc++;
        acc_evt = cmd_valid_i && cmd_ready_o;
        if (!reset_i) begin
            m_bus_left = 0; m_rsp = 0; m_pulse = 0; m_last_irq = 0;
            run_len = 0; acc_evt = 0; prev_rsp = 0;
        end else begin
            exp_idle = (m_bus_left == 0) && !m_rsp && !m_pulse;
            chk("address", 32'(address_o), (m_bus_left > 0) ? 32'(m_addr) : 32'(IDLE_ADDR));
            chk("rd_wr", 32'(rd_wr_o), (m_bus_left > 0) ? 32'(m_wr) : 32'd0);
            chk("wdata", 32'(data_o), (m_bus_left > 0) ? 32'(m_wdata) : 32'd0);
            chk("rsp_valid", 32'(rsp_valid_o), 32'(m_rsp));
            if (m_rsp) begin
                chk("rsp_data", 32'(rsp_data_o), 32'(m_res_data));
                chk("rsp_error", 32'(rsp_error_o), 32'(m_res_err));
            end
            chk("irq_pulse", 32'(irq_status_valid_o), 32'(m_pulse));
            if (m_pulse) begin
                chk("irq_status", 32'(irq_status_o), 32'(m_res_data));
                chk("irq_error", 32'(irq_error_o), 32'(m_res_err));
            end
            take_irq  = irq_i && !(m_last_irq && cmd_valid_i);
            exp_ready = exp_idle && !take_irq;
            chk("cmd_ready", 32'(cmd_ready_o), 32'(exp_ready));

            if (address_o != IDLE_ADDR) run_len++;
            else if (run_len > 0) begin last_len = run_len; run_len = 0; end
            if (acc_evt) acc_cyc = cyc;
            if (rsp_valid_o && !prev_rsp) rsp_rise_cyc = cyc;
            prev_rsp = rsp_valid_o;
            if (rsp_valid_o && rsp_ready_i) begin
                last_rsp_data = rsp_data_o; last_rsp_err = rsp_error_o;
            end
            if (irq_status_valid_o) begin
                pulse_count++; pulse_cyc = cyc; last_status = irq_status_o;
            end

            if (m_bus_left > 0) begin
                m_bus_left--;
                if (m_bus_left == 0) begin
                    if (m_irq) m_pulse = 1; else m_rsp = 1;
                end
            end else if (m_rsp) begin
                if (rsp_ready_i) m_rsp = 0;
            end else if (m_pulse) begin
                m_pulse = 0; m_last_irq = 1;
            end else if (take_irq || cmd_valid_i) begin
                if (take_irq) begin
                    m_addr = 16'h0003; m_wr = 0; m_wdata = '0; m_irq = 1;
                end else begin
                    m_addr = cmd_address_i; m_wr = cmd_write_i;
                    m_wdata = cmd_write_i ? cmd_data_i : 8'h00;
                    m_irq = 0; m_last_irq = 0;
                end
                if (m_addr >= 16'h0040) p_ack_at = 1000;
                else if (dir_plan) p_ack_at = next_ack_at;
                else p_ack_at = int'($urandom_range(1, T + 1));
                p_rdval = dir_plan ? next_rdval : 8'($urandom_range(0, 255));
                p_stale = dir_plan ? 1'b0 : 1'($urandom_range(0, 1));
                p_wr = m_wr;
                ok = (p_ack_at <= int'(T));
                m_bus_left = ok ? p_ack_at + 1 : int'(T) + 1;
                m_res_err  = !ok;
                m_res_data = (ok && !m_wr) ? p_rdval : 8'h00;
            end
        end
    end

    // Peripheral: acks at bus-cycle index p_ack_at, optional stale ack at index 0
    always begin
        @(posedge clk_i);
        #1;
        if (address_o != IDLE_ADDR) p_idx++; else p_idx = -1;
        begin
            bit hit, noise;
            hit   = (p_idx >= 0) && ((p_idx == p_ack_at) || (p_idx == 0 && p_stale));
            noise = noise_on ? 1'($urandom_range(0, 1)) : 1'b0;
            take_controlw_i = p_wr ? hit : noise;
            take_controlr_i = p_wr ? noise : hit;
            data_i = (p_idx == p_ack_at) ? p_rdval : 8'($urandom_range(0, 255));
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic send(input bit wr, input logic [15:0] a, input logic [7:0] d);
        cmd_write_i = wr; cmd_address_i = a; cmd_data_i = d; cmd_valid_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_i); #1;
            if (acc_evt) begin cmd_valid_i = 1'b0; return; end
        end
        cmd_valid_i = 1'b0;
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int pc0;
        bit seen;

        #1 reset_i = 1'b0;
        cmd_valid_i = 1'b1;
        #11;
        chk("rst_address", 32'(address_o), 32'hFFFF);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_rd_wr", 32'(rd_wr_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        chk("rst_irq_valid", 32'(irq_status_valid_o), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #1 reset_i = 1'b1;
        step(2);

        next_ack_at = 1; next_rdval = 8'h00;
        send(1'b1, 16'h0001, 8'hA5);
        step(6);
        chk("wr_bus_len", 32'(last_len), 32'd2);
        chk("wr_rsp_latency", 32'(rsp_rise_cyc - acc_cyc), 32'd3);
        chk("wr_rsp_data", 32'(last_rsp_data), 32'h00);
        chk("wr_rsp_err", 32'(last_rsp_err), 32'd0);

        next_ack_at = 3; next_rdval = 8'h3C;
        send(1'b0, 16'h0000, 8'h00);
        step(8);
        chk("rd_bus_len", 32'(last_len), 32'd4);
        chk("rd_rsp_data", 32'(last_rsp_data), 32'h3C);
        chk("rd_rsp_err", 32'(last_rsp_err), 32'd0);

        send(1'b0, 16'h0040, 8'h00);
        step(14);
        chk("to_bus_len", 32'(last_len), 32'd9);
        chk("to_rsp_data", 32'(last_rsp_data), 32'h00);
        chk("to_rsp_err", 32'(last_rsp_err), 32'd1);

        next_ack_at = T; next_rdval = 8'h5E;
        send(1'b0, 16'h0007, 8'h00);
        step(14);
        chk("lastack_len", 32'(last_len), 32'd9);
        chk("lastack_data", 32'(last_rsp_data), 32'h5E);
        chk("lastack_err", 32'(last_rsp_err), 32'd0);

        next_ack_at = T + 1;
        send(1'b0, 16'h0008, 8'h00);
        step(14);
        chk("lateack_err", 32'(last_rsp_err), 32'd1);

        // irq and command together: IRQ first, command next, then another IRQ
        next_ack_at = 1; next_rdval = 8'h04;
        pc0 = pulse_count;
        irq_i = 1'b1;
        send(1'b1, 16'h0010, 8'h5A);
        chk("irq_first_pulses", 32'(pulse_count - pc0), 32'd1);
        chk("irq_then_accept", 32'(acc_cyc - pulse_cyc), 32'd1);
        chk("irq_status_lit", 32'(last_status), 32'h04);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (pulse_count - pc0 >= 2) begin seen = 1; break; end
            step(1);
        end
        irq_i = 1'b0;
        chk("irq_second_seen", 32'(seen), 32'd1);
        step(6);
        chk("irq_pulse_total", 32'(pulse_count - pc0), 32'd2);

        // Response back-pressure with a second command waiting
        rsp_ready_i = 1'b0;
        next_ack_at = 1; next_rdval = 8'h77;
        send(1'b0, 16'h0005, 8'h00);
        cmd_write_i = 1'b0; cmd_address_i = 16'h0006; cmd_valid_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o) begin seen = 1; break; end
            step(1);
        end
        chk("hold_rsp_seen", 32'(seen), 32'd1);
        step(5);
        chk("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("hold_rsp_data", 32'(rsp_data_o), 32'h77);
        chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
        rsp_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (acc_evt) begin seen = 1; break; end
        end
        cmd_valid_i = 1'b0;
        chk("hold_resume", 32'(seen), 32'd1);
        step(8);

        // Reset in the third bus cycle of a long transaction
        send(1'b0, 16'h0050, 8'h00);
        @(posedge clk_i);
        @(posedge clk_i);
        #3 reset_i = 1'b0;
        #1;
        chk("mid_rst_address", 32'(address_o), 32'hFFFF);
        chk("mid_rst_rd_wr", 32'(rd_wr_o), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        @(posedge clk_i); #1 reset_i = 1'b1;
        step(12);
        next_ack_at = 2; next_rdval = 8'h00;
        send(1'b1, 16'h0002, 8'h33);
        step(8);
        chk("post_rst_len", 32'(last_len), 32'd3);
        chk("post_rst_err", 32'(last_rsp_err), 32'd0);

        // Randomized traffic against the model
        dir_plan = 0;
        noise_on = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #1;
            if (!cmd_valid_i || acc_evt) begin
                cmd_valid_i   = ($urandom_range(0, 99) < 40);
                cmd_write_i   = 1'($urandom_range(0, 1));
                cmd_address_i = 16'($urandom_range(0, 16'h005F));
                cmd_data_i    = 8'($urandom_range(0, 255));
            end
            irq_i       = ($urandom_range(0, 99) < 15);
            rsp_ready_i = ($urandom_range(0, 99) < 70);
        end
        cmd_valid_i = 1'b0; irq_i = 1'b0; rsp_ready_i = 1'b1;
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
# io_bus_master

Bus initiator for the memory-mapped 8-bit peripheral bus. It turns single read/write commands from an upstream client (debug bridge, DMA, soft sequencer) into bus cycles and waits for the peripheral's take-control acknowledge or a timeout. It also services interrupts on its own by reading the interrupt-status/clear register when `irq_i` is high. It sits between the upstream client and the shared peripheral bus, in place of the CPU core.

## Interface
- `address_width`, 16: bus and command address width.
- `data_width`, 8: bus and command data width.
- `TimeoutCycles`, 8: last counter value at which an ack is still accepted. Must be ≥1.
- `IdleAddress`, all ones: address driven when no transaction is active. Must be unmapped.
- `IrqStatusAddress`, 3: address read on interrupt service. Reading it clears the peripheral's IRQ.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `reset_i`  in  1  reset, asynchronous, active-low.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  command accepted on an edge where valid and ready are both 1.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_address_i`  in  address_width  target address.
- `cmd_data_i`  in  data_width  write data.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_data_o`  out  data_width  read data; 0 for writes and errors.
- `rsp_error_o`  out  1  timeout, no ack.
- `irq_status_valid_o`  out  1  one-cycle pulse per completed IRQ service.
- `irq_status_o`  out  data_width  value read from IrqStatusAddress; 0 on timeout.
- `irq_error_o`  out  1  IRQ service timed out; valid with the pulse.
- `address_o`  out  address_width  bus address.
- `data_o`  out  data_width  bus write data.
- `rd_wr_o`  out  1  1 = write, 0 = read.
- `data_i`  in  data_width  bus read data, already OR/muxed across peripherals.
- `take_controlr_i`  in  1  read ack.
- `take_controlw_i`  in  1  write ack.
- `irq_i`  in  1  combined peripheral interrupt.

## Operation
- FSM states:
  - IDLE: bus shows `IdleAddress`, `rd_wr_o`=0, `data_o`=0. Arbitration:
    - If `irq_i`=1 and NOT (`last_irq`=1 and `cmd_valid_i`=1): load an IRQ read of `IrqStatusAddress` and go to BUS; `cmd_ready_o`=0.
    - Else `cmd_ready_o`=1. On accept, latch the command, clear `last_irq`, go to BUS.
  - BUS: address, `rd_wr_o` and `data_o` (write data for writes, 0 for reads) are registered and held every cycle. Counter `cnt` is 0 in the first BUS cycle and increments each cycle.
    - Ack = `take_controlw_i` for writes, `take_controlr_i` for reads. An ack is ignored while `cnt`=0 (stale).
    - Ack with `cnt`≥1: capture `data_i` (reads), error=0, release the bus to idle.
    - No ack with `cnt`=`TimeoutCycles`: data=0, error=1, release the bus.
    - Next state is RESP for a command, IRQDONE for an IRQ transaction.
  - RESP: `rsp_valid_o`=1 with data and error stable until `rsp_ready_i`=1, then IDLE.
  - IRQDONE: one cycle. `irq_status_valid_o`=1 with status and error, set `last_irq`=1, then IDLE.
- Fairness: a command that is waiting when an IRQ service completes wins the next IDLE cycle, even if `irq_i` is still high.
- `cnt` width is clog2(TimeoutCycles+1). It is saturating, never wraps, and clears on leaving BUS.
- An asynchronous reset in any state:
  - returns the FSM to IDLE and clears `last_irq` and `cnt`;
  - drops the in-flight transaction with no response.
- Reset values:
  - `address_o`=`IdleAddress`; `data_o`, `rd_wr_o`=0;
  - `rsp_valid_o`, `rsp_data_o`, `rsp_error_o`=0;
  - `irq_status_valid_o`, `irq_status_o`, `irq_error_o`=0;
  - `cmd_ready_o` is forced 0 while `reset_i`=0.

## Timing
- Acceptance edge E0. The bus is driven from E0 until release.
- Zero-wait peripheral, ack seen in the cycle after E1:
  - bus driven for 2 cycles;
  - `rsp_valid_o` or `irq_status_valid_o` high after E2, i.e. 2 clocks after acceptance.
- Timeout: bus driven for TimeoutCycles+1 cycles; response after edge E(TimeoutCycles+1).
- Accept-to-accept throughput is at least 4 cycles with `rsp_ready_i` tied to 1.
- `cmd_ready_o` is combinational from state, `irq_i`, `cmd_valid_i` and `last_irq`. All other outputs are registered.

## Test plan
- Write 0xA5 to 0x0001, model acks 1 cycle after sampling.
  - Bus shows address 0x0001, `rd_wr_o`=1, `data_o`=0xA5 for 2 cycles, then idle.
  - `rsp_valid_o` 2 clocks after accept, `rsp_error_o`=0, `rsp_data_o`=0.
- Read 0x0000, model returns 0x3C with a read ack after 3 wait cycles.
  - `rsp_data_o`=0x3C, `rsp_error_o`=0, bus held 4 cycles.
- Read unmapped 0x0040.
  - Bus held 9 cycles, `rsp_error_o`=1, `rsp_data_o`=0.
- `irq_i` and `cmd_valid_i` rise together, status model returns 0x04 and keeps `irq_i` high.
  - IRQ read of address 3 first; `irq_status_valid_o` pulses once with 0x04.
  - The command is accepted in the next IDLE cycle, then a second IRQ service follows.
- Hold `rsp_ready_i`=0 for 5 cycles after a read response.
  - `rsp_valid_o` and data stay stable; `cmd_ready_o`=0 throughout; accept resumes after the handshake.
- Assert `reset_i`=0 in the third BUS cycle.
  - All outputs take reset values immediately and `address_o`=`IdleAddress`.
  - No response after release; the next command completes normally.
